// File: rtl/lifo_rr_arbiter_if.sv
// Client-side bundle for lifo_rr_arbiter: per-client push/pop requests and data,
// one-hot grant, and the tagged pop-return channel.
interface lifo_rr_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [1:0]        req_push;
  logic [1:0]        req_pop;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rvalid;

  // Clients drive requests and observe grant/return
  modport master (
    output req_push, req_pop, req_data0, req_data1,
    input  gnt, rdata, rvalid
  );

  // Arbiter side
  modport slave (
    input  req_push, req_pop, req_data0, req_data1,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/lifo_rr_arbiter.sv
// Round-robin arbiter sharing one LIFO between two clients, with occupancy tracking
// and tagged pop return. Optional sticky illegal-request flags under LIFO_RR_ARBITER_ERR_EN.
module lifo_rr_arbiter #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  lifo_rr_arbiter_if.slave    cl,
  output logic                lifo_wr_en,
  output logic                lifo_rd_en,
  output logic [DATA_W-1:0]   lifo_data_in,
  input  logic [DATA_W-1:0]   lifo_data_out,
  output logic [CNT_W-1:0]    count,
  output logic                empty,
  output logic                full
`ifdef LIFO_RR_ARBITER_ERR_EN
  ,
  output logic                err,
  output logic [1:0]          err_src
`endif
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_q, last_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_id_q, pend_id_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] push_ok;
  logic [1:0] pop_ok;
  logic [1:0] elig;
  logic [1:0] gnt_c;
  logic       win_id;
  logic       win_any;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // Eligibility: exactly one of push/pop, gated by occupancy; nothing during reset
  always_comb begin
    push_ok = cl.req_push & ~cl.req_pop & {2{~full}};
    pop_ok  = cl.req_pop & ~cl.req_push & {2{~empty}};
    elig    = (push_ok | pop_ok) & {2{~rst}};
  end

  // Round-robin pick: on contention the client that did not win last time goes
  always_comb begin
    gnt_c = 2'b00;
    case (elig)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

  assign win_id  = gnt_c[1];
  assign win_any = |gnt_c;

  assign cl.gnt       = gnt_c;
  assign lifo_wr_en   = win_any & cl.req_push[win_id];
  assign lifo_rd_en   = win_any & cl.req_pop[win_id];
  assign lifo_data_in = gnt_c[1] ? cl.req_data1 : cl.req_data0;

  // Next state: occupancy, priority pointer and the one-deep pop-return pipeline
  always_comb begin
    count_d   = count_q;
    last_d    = last_q;
    pend_v_d  = lifo_rd_en;
    pend_id_d = win_id;
    rvalid_d  = 2'b00;
    rdata_d   = rdata_q;

    if (win_any) begin
      last_d = win_id;
    end
    if (lifo_wr_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (lifo_rd_en) begin
      count_d = count_q - CNT_W'(1);
    end

    // LIFO data_out is valid the cycle after rd_en; capture it and tag the owner
    if (pend_v_q) begin
      rvalid_d = pend_id_q ? 2'b10 : 2'b01;
      rdata_d  = lifo_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      last_q    <= 1'b1;
      pend_v_q  <= 1'b0;
      pend_id_q <= 1'b0;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
    end else begin
      count_q   <= count_d;
      last_q    <= last_d;
      pend_v_q  <= pend_v_d;
      pend_id_q <= pend_id_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cl.rvalid = rvalid_q;
  assign cl.rdata  = rdata_q;

`ifdef LIFO_RR_ARBITER_ERR_EN
  logic [1:0] illegal_c;
  logic       err_q, err_d;
  logic [1:0] err_src_q, err_src_d;

  // Sticky record of clients that asserted push and pop together
  always_comb begin
    illegal_c = cl.req_push & cl.req_pop;
    err_src_d = err_src_q | illegal_c;
    err_d     = err_q | (|illegal_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_src_q <= 2'b00;
    end else begin
      err_q     <= err_d;
      err_src_q <= err_src_d;
    end
  end

  assign err     = err_q;
  assign err_src = err_src_q;
`endif

endmodule

// File: tb/tb_lifo_rr_arbiter.sv
// Bench for lifo_rr_arbiter: directed test-plan steps followed by random traffic,
// checked against a queue-based reference model; includes a behavioural LIFO.
module tb_lifo_rr_arbiter;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lifo_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  logic              wr_en, rd_en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  count;
  logic              empty, full;
`ifdef LIFO_RR_ARBITER_ERR_EN
  logic              err;
  logic [1:0]        err_src;
`endif

  lifo_rr_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cl            (bus),
    .lifo_wr_en    (wr_en),
    .lifo_rd_en    (rd_en),
    .lifo_data_in  (din),
    .lifo_data_out (dout),
    .count         (count),
    .empty         (empty),
    .full          (full)
`ifdef LIFO_RR_ARBITER_ERR_EN
    ,
    .err           (err),
    .err_src       (err_src)
`endif
  );

  // Attached LIFO; the system discards its contents whenever the arbiter is reset
  logic [DATA_W-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
    end else if (wr_en && sp < int'(DEPTH)) begin
      mem[sp] <= din;
      sp      <= sp + 1;
    end else if (rd_en && sp > 0) begin
      dout <= mem[sp-1];
      sp   <= sp - 1;
    end
  end

  // Reference model state
  logic [7:0] m_stack [$];
  int         m_last;
  bit         m_pv;
  int         m_pid;
  logic [7:0] m_pdata;
  logic [1:0] m_rvalid;
  logic [7:0] m_rdata;
  bit         m_err;
  logic [1:0] m_esrc;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] g_dut;
  logic [1:0] g_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_gnt(input logic [1:0] p, input logic [1:0] q, input bit r);
    bit ok [2];
    if (r) return 2'b00;
    for (int i = 0; i < 2; i++)
      ok[i] = (p[i] && !q[i] && m_stack.size() < int'(DEPTH)) ||
              (q[i] && !p[i] && m_stack.size() > 0);
    if (ok[0] && ok[1]) return (m_last == 1) ? 2'b01 : 2'b10;
    if (ok[0]) return 2'b01;
    if (ok[1]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_stack.delete();
    m_last   = 1;
    m_pv     = 0;
    m_pid    = 0;
    m_pdata  = '0;
    m_rvalid = 2'b00;
    m_rdata  = '0;
    m_err    = 0;
    m_esrc   = 2'b00;
  endtask

  // One clock: drive, check grant side, clock, update model, check registered side
  task automatic cycle(input logic [1:0] p, input logic [1:0] q,
                       input logic [7:0] d0, input logic [7:0] d1, input bit r);
    int w;
    @(negedge clk);
    rst           = r;
    bus.req_push  = p;
    bus.req_pop   = q;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    #1;
    g_exp = exp_gnt(p, q, r);
    g_dut = bus.gnt;
    w     = g_exp[1] ? 1 : 0;
    chk("gnt", 32'(bus.gnt), 32'(g_exp));
    chk("wr_en", 32'(wr_en), 32'((g_exp != 0) && p[w]));
    chk("rd_en", 32'(rd_en), 32'((g_exp != 0) && q[w]));
    chk("data_in", 32'(din), 32'(g_exp[1] ? d1 : d0));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_rvalid = m_pv ? ((m_pid == 1) ? 2'b10 : 2'b01) : 2'b00;
      if (m_pv) m_rdata = m_pdata;
      m_pv = 0;
      if (g_exp != 0) begin
        m_last = w;
        if (p[w]) begin
          m_stack.push_back(w == 1 ? d1 : d0);
        end else begin
          m_pdata = m_stack.pop_back();
          m_pv    = 1;
          m_pid   = w;
        end
      end
      if ((p & q) != 0) m_err = 1;
      m_esrc = m_esrc | (p & q);
    end
    #1;
    chk("count", 32'(count), 32'(m_stack.size()));
    chk("empty", 32'(empty), 32'(m_stack.size() == 0));
    chk("full", 32'(full), 32'(m_stack.size() == int'(DEPTH)));
    chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    chk("rdata", 32'(bus.rdata), 32'(m_rdata));
`ifdef LIFO_RR_ARBITER_ERR_EN
    chk("err", 32'(err), 32'(m_err));
    chk("err_src", 32'(err_src), 32'(m_esrc));
`endif
  endtask

  initial begin
    int n0, n1;
    bus.req_push  = 2'b00;
    bus.req_pop   = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    model_reset();

    // Reset
    cycle(2'b11, 2'b00, 8'h00, 8'h00, 1);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 1);

    // Client 0 fills the LIFO, then a 17th push is held without grant
    for (int n = 0; n < 16; n++) cycle(2'b01, 2'b00, 8'(8'h10 + n), 8'h00, 0);
    chk("fill_full", 32'(full), 32'd1);
    cycle(2'b01, 2'b00, 8'h20, 8'h00, 0);
    chk("held_push", 32'(g_dut), 32'd0);

    // Client 1 drains it in reverse order; 17th pop gets nothing
    for (int n = 0; n < 16; n++) cycle(2'b00, 2'b10, 8'h00, 8'h00, 0);
    cycle(2'b00, 2'b10, 8'h00, 8'h00, 0);
    chk("pop_empty_gnt", 32'(g_dut), 32'd0);
    chk("last_rdata", 32'(bus.rdata), 32'h10);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 0);
    chk("no_rvalid", 32'(bus.rvalid), 32'd0);

    // Both push continuously; each client advances its data when granted
    n0 = 0;
    n1 = 0;
    for (int n = 0; n < 16; n++) begin
      cycle(2'b11, 2'b00, 8'(8'hA0 + n0), 8'(8'hB0 + n1), 0);
      chk("alt_gnt", 32'(g_dut), 32'((n % 2 == 0) ? 2'b01 : 2'b10));
      if (g_exp[0]) n0++;
      if (g_exp[1]) n1++;
    end
    chk("both_full", 32'(count), 32'd16);

    // Full: client 1's pop wins over client 0's push, then the push proceeds
    cycle(2'b01, 2'b10, 8'hC0, 8'h00, 0);
    chk("full_pop_wins", 32'(g_dut), 32'b10);
    cycle(2'b01, 2'b00, 8'hC0, 8'h00, 0);
    chk("push_after", 32'(g_dut), 32'b01);
    chk("rvalid_c1", 32'(bus.rvalid), 32'b10);
    chk("rdata_c1", 32'(bus.rdata), 32'hB7);

    // Illegal push+pop from client 0 alongside a legal push from client 1
    cycle(2'b00, 2'b10, 8'h00, 8'h00, 0);
    cycle(2'b11, 2'b01, 8'h00, 8'h55, 0);
    chk("illegal_gnt", 32'(g_dut), 32'b10);
    chk("illegal_cnt", 32'(count), 32'd16);
    for (int n = 0; n < 3; n++) cycle(2'b00, 2'b00, 8'h00, 8'h00, 0);

    // Reset right after a pop grant at count 3 suppresses the return
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 1);
    for (int n = 0; n < 3; n++) cycle(2'b01, 2'b00, 8'(8'h30 + n), 8'h00, 0);
    cycle(2'b00, 2'b10, 8'h00, 8'h00, 0);
    chk("pop_at3", 32'(g_dut), 32'b10);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 1);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    cycle(2'b11, 2'b00, 8'h61, 8'h62, 0);
    chk("post_rst_gnt", 32'(g_dut), 32'b01);

    // Random traffic, including illegal requests and occasional resets
    for (int n = 0; n < 800; n++) begin
      logic [1:0] p, q;
      p = 2'($urandom);
      q = 2'($urandom);
      if (n < 200) q = q & 2'($urandom);
      cycle(p, q, 8'($urandom), 8'($urandom), ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
